// File: rtl/i2c_codec_responder.sv
// i2c_codec_responder
// Write-only I2C responder standing in for the audio codec control port.
// Decodes 3-byte frames (device byte, {addr[6:0], data[8]}, data[7:0]),
// ACKs by pulling SDA low, and commits writes into a 16 x 9-bit register
// file that the surrounding logic can read back.
//
// Ports:
//   i_clk       system clock (>= 8x SCL frequency)
//   i_rst       synchronous active-high reset
//   i_scl/i_sda raw bus lines (asynchronous, synchronized here)
//   o_sda_oe    1 = pull SDA low (ACK), 0 = release
//   o_wr_valid  one-cycle strobe per committed write
//   o_wr_addr   register address of the last committed write
//   o_wr_data   data of the last committed write
//   i_rd_addr   register file read index
//   o_rd_data   combinational read of reg[i_rd_addr]
//   o_state     current FSM state, for debug
module i2c_codec_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [8:0] o_wr_data,
    input  logic [3:0] i_rd_addr,
    output logic [8:0] o_rd_data,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEV     = 3'd1,
        S_ACK_DEV = 3'd2,
        S_BYTE_HI = 3'd3,
        S_ACK_HI  = 3'd4,
        S_BYTE_LO = 3'd5,
        S_ACK_LO  = 3'd6,
        S_IGNORE  = 3'd7
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [1:0]  scl_sync_r;
    logic [1:0]  sda_sync_r;
    logic        scl_hist_r;
    logic        sda_hist_r;
    logic [7:0]  shift_r;
    logic [2:0]  bit_cnt_r;
    logic        byte_full_r;
    logic [6:0]  addr_r;
    logic        data_hi_r;
    logic        sda_oe_r;
    logic        wr_valid_r;
    logic [6:0]  wr_addr_r;
    logic [8:0]  wr_data_r;
    logic [8:0]  regs_r [16];

    logic        scl_s;
    logic        sda_s;
    logic        scl_rise_s;
    logic        scl_fall_s;
    logic        start_s;
    logic        stop_s;
    logic        byte_done_s;
    logic        in_byte_s;
    logic        sda_oe_next_s;
    logic        commit_s;

    // Two-stage synchronizers plus a history stage for edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_hist_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], i_scl};
            sda_sync_r <= {sda_sync_r[0], i_sda};
            scl_hist_r <= scl_sync_r[1];
            sda_hist_r <= sda_sync_r[1];
        end
    end

    assign scl_s      = scl_sync_r[1];
    assign sda_s      = sda_sync_r[1];
    assign scl_rise_s = scl_s & ~scl_hist_r;
    assign scl_fall_s = ~scl_s & scl_hist_r;
    // SCL must be high in both samples, so an SDA change coinciding with an
    // SCL change is treated as data rather than a bus condition.
    assign start_s    = scl_s & scl_hist_r & ~sda_s & sda_hist_r;
    assign stop_s     = scl_s & scl_hist_r & sda_s & ~sda_hist_r;
    assign byte_done_s = scl_fall_s & byte_full_r;
    assign in_byte_s  = (state_r == S_DEV) || (state_r == S_BYTE_HI) || (state_r == S_BYTE_LO);

    // Next-state logic; START/STOP override bit processing in every state.
    always_comb begin
        state_next_s = state_r;
        if (start_s) begin
            state_next_s = S_DEV;
        end else if (stop_s) begin
            state_next_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:    state_next_s = S_IDLE;
                S_DEV: begin
                    if (byte_done_s) begin
                        state_next_s = (shift_r == {DEV_ADDR, 1'b0}) ? S_ACK_DEV : S_IGNORE;
                    end else begin
                        state_next_s = S_DEV;
                    end
                end
                S_ACK_DEV: state_next_s = scl_fall_s  ? S_BYTE_HI : S_ACK_DEV;
                S_BYTE_HI: state_next_s = byte_done_s ? S_ACK_HI  : S_BYTE_HI;
                S_ACK_HI:  state_next_s = scl_fall_s  ? S_BYTE_LO : S_ACK_HI;
                S_BYTE_LO: state_next_s = byte_done_s ? S_ACK_LO  : S_BYTE_LO;
                S_ACK_LO:  state_next_s = scl_fall_s  ? S_IGNORE  : S_ACK_LO;
                S_IGNORE:  state_next_s = S_IGNORE;
                default:   state_next_s = S_IDLE;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs move on
    // the same edge as the state register.
    always_comb begin
        sda_oe_next_s = 1'b0;
        commit_s      = 1'b0;
        if ((state_next_s == S_ACK_DEV) || (state_next_s == S_ACK_HI) ||
            (state_next_s == S_ACK_LO)) begin
            sda_oe_next_s = 1'b1;
        end else begin
            sda_oe_next_s = 1'b0;
        end
        if ((state_r == S_BYTE_LO) && (state_next_s == S_ACK_LO)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r    <= S_IDLE;
            sda_oe_r   <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= 7'h00;
            wr_data_r  <= 9'h000;
        end else begin
            state_r    <= state_next_s;
            sda_oe_r   <= sda_oe_next_s;
            wr_valid_r <= commit_s;
            if (commit_s) begin
                wr_addr_r <= addr_r;
                wr_data_r <= {data_hi_r, shift_r};
            end
        end
    end

    // Bit shifter, bit counter and the latched address / data MSB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            byte_full_r <= 1'b0;
            addr_r      <= 7'h00;
            data_hi_r   <= 1'b0;
        end else if (start_s || stop_s) begin
            shift_r     <= 8'h00;
            bit_cnt_r   <= 3'd0;
            byte_full_r <= 1'b0;
        end else begin
            if (scl_rise_s && in_byte_s && !byte_full_r) begin
                shift_r   <= {shift_r[6:0], sda_s};
                bit_cnt_r <= bit_cnt_r + 3'd1;
                if (bit_cnt_r == 3'd7) begin
                    byte_full_r <= 1'b1;
                end
            end
            if (byte_done_s) begin
                byte_full_r <= 1'b0;
            end
            if ((state_r == S_BYTE_HI) && byte_done_s) begin
                addr_r    <= shift_r[7:1];
                data_hi_r <= shift_r[0];
            end
        end
    end

    // Register file, updated the cycle after the strobe; 7'h0F clears all.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= 9'h000;
            end
        end else if (wr_valid_r) begin
            if (wr_addr_r == 7'h0F) begin
                for (int i = 0; i < 16; i++) begin
                    regs_r[i] <= 9'h000;
                end
            end else if (wr_addr_r[6:4] == 3'b000) begin
                regs_r[wr_addr_r[3:0]] <= wr_data_r;
            end
        end
    end

    assign o_sda_oe   = sda_oe_r;
    assign o_wr_valid = wr_valid_r;
    assign o_wr_addr  = wr_addr_r;
    assign o_wr_data  = wr_data_r;
    assign o_rd_data  = regs_r[i_rd_addr];
    assign o_state    = state_r;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Self-checking bench for i2c_codec_responder: a table of 3-byte frames
// followed by hand-written sequences for STOP abort, repeated START,
// extra-byte NACK and reset mid-frame.
module tb_i2c_codec_responder;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic [3:0] rd_addr = 4'd0;
    logic [8:0] rd_data;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // monitor state (written only by the monitor process)
    int         strobe_cnt = 0;
    int         oe_cycles = 0;
    int         oe_edges = 0;
    int         lat_err = 0;
    int         wide_err = 0;
    int         coincide_err = 0;
    int         since_fall = 100;
    logic [6:0] last_addr = 7'h00;
    logic [8:0] last_data = 9'h000;
    logic       mon_scl_prev = 1'b1;
    logic       mon_oe_prev = 1'b0;
    logic       mon_valid_prev = 1'b0;
    logic       mon_en = 1'b0;

    assign sda_bus = sda_drv & ~sda_oe;

    always #5 clk = ~clk;

    i2c_codec_responder dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_scl      (scl),
        .i_sda      (sda_bus),
        .o_sda_oe   (sda_oe),
        .o_wr_valid (wr_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_state    (state)
    );

    // Sample just after each rising edge: strobes, SDA ownership, latency.
    always @(posedge clk) begin
        #1;
        if (mon_scl_prev && !scl) since_fall = 1;
        else if (since_fall < 100) since_fall++;
        mon_scl_prev = scl;
        if (mon_en) begin
            if (sda_oe != mon_oe_prev) begin
                oe_edges++;
                if (since_fall != 3) lat_err++;
            end
            if (sda_oe) oe_cycles++;
            if (wr_valid) begin
                strobe_cnt++;
                last_addr = wr_addr;
                last_data = wr_data;
                if (mon_valid_prev) wide_err++;
                if (!(sda_oe && !mon_oe_prev)) coincide_err++;
            end
        end
        mon_oe_prev    = sda_oe;
        mon_valid_prev = wr_valid;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(Q); sda_drv = b;
        wait_clk(Q); scl = 1'b1;
        wait_clk(2 * Q); scl = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) send_bit(v[7 - i]);
    endtask

    task automatic ack_bit(output logic ack);
        wait_clk(Q); sda_drv = 1'b1;
        wait_clk(Q); scl = 1'b1;
        wait_clk(Q); ack = sda_oe;
        wait_clk(Q); scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        send_bits(v, 8);
        ack_bit(ack);
    endtask

    task automatic bus_start();
        wait_clk(Q); sda_drv = 1'b1;
        wait_clk(Q); scl = 1'b1;
        wait_clk(2 * Q); sda_drv = 1'b0;
        wait_clk(2 * Q); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q); sda_drv = 1'b0;
        wait_clk(Q); scl = 1'b1;
        wait_clk(2 * Q); sda_drv = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic read_reg(input logic [3:0] idx, output logic [8:0] val);
        @(negedge clk); rd_addr = idx;
        @(negedge clk); val = rd_data;
    endtask

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [2:0] exp_ack;
        int         exp_strobes;
        logic [6:0] exp_addr;
        logic [8:0] exp_data;
        logic [3:0] rd_idx;
        logic [8:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [2:0] acks;
        logic       a;
        logic [8:0] rv;
        int         s0;
        int         oe0;

        vecs[0] = '{8'h34, 8'h08, 8'h19, 3'b111, 1, 7'h04, 9'h019, 4'd4,  9'h019};
        vecs[1] = '{8'h36, 8'h08, 8'h19, 3'b000, 0, 7'h04, 9'h019, 4'd4,  9'h019};
        vecs[2] = '{8'h34, 8'h04, 8'h79, 3'b111, 1, 7'h02, 9'h079, 4'd2,  9'h079};
        vecs[3] = '{8'h34, 8'h1E, 8'h00, 3'b111, 1, 7'h0F, 9'h000, 4'd2,  9'h000};
        vecs[4] = '{8'h34, 8'h0B, 8'h55, 3'b111, 1, 7'h05, 9'h155, 4'd5,  9'h155};
        vecs[5] = '{8'h34, 8'h21, 8'hAA, 3'b111, 1, 7'h10, 9'h1AA, 4'd0,  9'h000};
        vecs[6] = '{8'h35, 8'h1D, 8'h33, 3'b000, 0, 7'h10, 9'h1AA, 4'd14, 9'h000};
        vecs[7] = '{8'h34, 8'h1D, 8'h33, 3'b111, 1, 7'h0E, 9'h133, 4'd14, 9'h133};
        vecs[8] = '{8'h34, 8'h08, 8'h42, 3'b111, 1, 7'h04, 9'h042, 4'd4,  9'h042};

        // reset state
        @(negedge clk); rst = 1'b1;
        wait_clk(2); rst = 1'b0;
        mon_en = 1'b1;
        wait_clk(2);
        check("rst_state", state, 0);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        read_reg(4'd7, rv);
        check("rst_reg7", rv, 0);

        // table-driven frames
        for (int v = 0; v < 9; v++) begin
            s0 = strobe_cnt;
            bus_start();
            send_byte(vecs[v].b0, a); acks[2] = a;
            send_byte(vecs[v].b1, a); acks[1] = a;
            send_byte(vecs[v].b2, a); acks[0] = a;
            bus_stop();
            wait_clk(4);
            check($sformatf("v%0d_acks", v), acks, vecs[v].exp_ack);
            check($sformatf("v%0d_strobes", v), strobe_cnt - s0, vecs[v].exp_strobes);
            check($sformatf("v%0d_addr", v), last_addr, vecs[v].exp_addr);
            check($sformatf("v%0d_data", v), last_data, vecs[v].exp_data);
            check($sformatf("v%0d_state", v), state, 0);
            read_reg(vecs[v].rd_idx, rv);
            check($sformatf("v%0d_rd", v), rv, vecs[v].exp_rd);
        end
        read_reg(4'd5, rv);
        check("reg5_kept", rv, 9'h155);

        // STOP after 4 bits of byte 3
        s0 = strobe_cnt;
        bus_start();
        send_byte(8'h34, a);
        send_byte(8'h08, a);
        send_bits(8'h19, 4);
        check("partial_mid_state", state, 5);
        bus_stop();
        wait_clk(4);
        check("partial_strobes", strobe_cnt - s0, 0);
        check("partial_state", state, 0);
        read_reg(4'd4, rv);
        check("partial_reg4", rv, 9'h042);

        // repeated START
        s0 = strobe_cnt;
        bus_start();
        send_byte(8'h34, a);
        send_byte(8'h0A, a);
        bus_start();
        send_byte(8'h34, a);
        send_byte(8'h0C, a);
        send_byte(8'h01, a);
        check("rstart_ack3", a, 1);
        bus_stop();
        wait_clk(4);
        check("rstart_strobes", strobe_cnt - s0, 1);
        check("rstart_addr", last_addr, 7'h06);
        check("rstart_data", last_data, 9'h001);
        read_reg(4'd6, rv);
        check("rstart_reg6", rv, 9'h001);
        read_reg(4'd5, rv);
        check("rstart_reg5", rv, 9'h155);

        // fourth byte in a frame is NACKed
        s0 = strobe_cnt;
        bus_start();
        send_byte(8'h34, a);
        send_byte(8'h10, a);
        send_byte(8'h07, a);
        send_byte(8'h99, a);
        check("extra_nack", a, 0);
        bus_stop();
        wait_clk(4);
        check("extra_strobes", strobe_cnt - s0, 1);
        check("extra_addr", last_addr, 7'h08);
        check("extra_data", last_data, 9'h007);

        // reset during byte 2, then a clean frame
        s0 = strobe_cnt;
        bus_start();
        send_byte(8'h34, a);
        send_bits(8'h12, 4);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        wait_clk(1);
        check("rstmid_state", state, 0);
        check("rstmid_sda_oe", sda_oe, 0);
        oe0 = oe_cycles;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        ack_bit(a); acks[1] = a;
        send_byte(8'h01, a); acks[0] = a;
        bus_stop();
        wait_clk(4);
        check("rstmid_acks", acks[1:0], 0);
        check("rstmid_oe_cycles", oe_cycles - oe0, 0);
        check("rstmid_strobes", strobe_cnt - s0, 0);
        read_reg(4'd4, rv);
        check("rstmid_reg4", rv, 0);
        s0 = strobe_cnt;
        bus_start();
        send_byte(8'h34, a);
        send_byte(8'h12, a);
        send_byte(8'h01, a);
        bus_stop();
        wait_clk(4);
        check("post_rst_strobes", strobe_cnt - s0, 1);
        check("post_rst_addr", last_addr, 7'h09);
        read_reg(4'd9, rv);
        check("post_rst_reg9", rv, 9'h001);

        // timing properties gathered over the whole run
        check("oe_edges_seen", (oe_edges > 0) ? 1 : 0, 1);
        check("oe_latency", lat_err, 0);
        check("strobe_width", wide_err, 0);
        check("strobe_with_ack", coincide_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_codec_responder.md
# i2c_codec_responder

I2C write-only responder that models the audio codec's control port. It sits on the same open-drain SCL/SDA pair our configuration initiator drives, and lets the initiator and codec-config logic be exercised on-chip or in simulation without the physical codec. It decodes 3-byte write frames (device byte, then 7-bit register address plus 9-bit data), drives ACK/NACK, and commits writes into a 16-entry × 9-bit register file with a read port and a write-strobe output.

## Interface
- DEV_ADDR, 7'h1A, 7-bit device address to acknowledge (write byte 0x34).
- i_clk  in  1  system clock; must be ≥ 8× SCL frequency; each SCL high/low phase is ≥ 4 i_clk periods.
- i_rst  in  1  reset, synchronous and active-high.
- i_scl  in  1  raw SCL from the bus (asynchronous).
- i_sda  in  1  raw SDA from the bus (asynchronous).
- o_sda_oe  out  1  1 = pull SDA low (ACK); 0 = release. External tri-state maps it to the inout.
- o_wr_valid  out  1  one-cycle strobe on each committed write.
- o_wr_addr  out  7  register address of the last committed write.
- o_wr_data  out  9  data of the last committed write.
- i_rd_addr  in  4  register file read index.
- o_rd_data  out  9  combinational read of reg[i_rd_addr].
- o_state  out  3  current FSM state encoding, for debug.

## Operation
- Input conditioning:
  - i_scl and i_sda each pass through a 2-FF synchronizer plus a history FF.
  - Edges are detected from sync stage 2 versus the history FF.
- Bus conditions, both evaluated on synchronized signals:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - START and STOP take priority over bit processing in every state.
- Bit sampling:
  - Data bits are sampled on the SCL rising edge, MSB first, into an 8-bit shift register with a 3-bit bit counter.
  - Byte completion is acted on at the SCL falling edge that follows the 8th bit.
- FSM states: S_IDLE, S_DEV, S_ACK_DEV, S_BYTE_HI, S_ACK_HI, S_BYTE_LO, S_ACK_LO, S_IGNORE.
  - S_IDLE: START → S_DEV, bit count cleared.
  - S_DEV: after 8 bits, compare the byte with {DEV_ADDR, 1'b0}.
    - Match → S_ACK_DEV with o_sda_oe = 1.
    - Mismatch, including R/W = 1 → S_IGNORE, SDA released (NACK).
  - S_ACK_DEV: at the next SCL falling edge, release SDA → S_BYTE_HI.
  - S_BYTE_HI: after 8 bits, latch addr = byte[7:1] and data[8] = byte[0]; ACK → S_ACK_HI.
  - S_ACK_HI: at the next SCL falling edge, release → S_BYTE_LO.
  - S_BYTE_LO: after 8 bits, latch data[7:0], commit the write, ACK → S_ACK_LO.
  - S_ACK_LO: at the next SCL falling edge, release → S_IGNORE. Any further bytes in the frame are NACKed (there is no auto-increment).
  - S_IGNORE: SDA released; wait for START (→ S_DEV) or STOP (→ S_IDLE).
- Commit rules:
  - o_wr_valid pulses for every committed write; o_wr_addr and o_wr_data update on the same cycle.
  - Address 7'h0F (reset register): all 16 registers clear to 0. The write is still strobed.
  - Address 0x00–0x0E: reg[addr[3:0]] <= data.
  - Address ≥ 0x10: ACKed and strobed; register file unchanged.
- STOP in any state → S_IDLE, SDA released, partial frame discarded, no strobe.
- START in any non-idle state (repeated start) → S_DEV with the shift register cleared.

## Timing
- Reset (synchronous, i_rst high at a rising i_clk edge) forces:
  - o_state = S_IDLE, o_sda_oe = 0, o_wr_valid = 0, o_wr_addr = 0, o_wr_data = 0.
  - All registers = 0, synchronizers = 1 (idle bus).
- Reset mid-frame aborts the frame with no strobe. Immediately after reset, the responder ignores bus activity until the next START.
- Detection latency is 3 i_clk cycles from a raw SCL/SDA transition to the registered FSM reaction. This covers START/STOP, the ACK assert/release on o_sda_oe, and the o_wr_valid strobe.
  - ACK is asserted 3 cycles after the raw SCL falling edge ending bit 8.
  - ACK is held until 3 cycles after the next raw SCL falling edge.
- o_wr_valid is high for exactly 1 i_clk cycle. It coincides with the o_sda_oe rise for the third byte.
- o_rd_data reflects a commit on the cycle after the o_wr_valid edge.
- Simultaneous SCL and SDA change in the same sample: treated as a data transition, not as START or STOP.

## Test plan
- Frame 0x34, 0x08, 0x19 → ACK on all three bytes; o_wr_valid pulse with addr 7'h04, data 9'h019; reg[4] reads 0x019.
- Frame 0x36, 0x08, 0x19 → SDA never pulled low, no strobe, all registers unchanged.
- Write reg 2 = 0x079, then frame 0x34, 0x1E, 0x00 → strobe addr 0x0F, data 0; reg[2] reads 0.
- Frame 0x34, 0x08, then STOP after 4 bits of byte 3 → no strobe; state returns to S_IDLE; reg[4] keeps its old value.
- Frame 0x34, 0x0A, repeated START, 0x34, 0x0C, 0x01 → single strobe with addr 0x06, data 0x001.
- Assert i_rst for 1 cycle during byte 2 of a valid frame → o_sda_oe = 0 and no strobe; a following full frame 0x34, 0x12, 0x01 commits reg[9] = 0x001.
